// File: rtl/barrett_pkg.sv
// Shared types and helpers for the Barrett datapath blocks.
package barrett_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Width of a counter that must hold 0..depth-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/Multiplier_4xN.sv
// Combinational 4-bit digit times n-bit operand; result is n+4 bits wide.
module Multiplier_4xN
  import barrett_pkg::*;
#(
  parameter int n = 8
) (
  input  logic [DIGIT_W-1:0]   digit,
  input  logic [n-1:0]         b,
  output logic [n+DIGIT_W-1:0] pp
);

  assign pp = (n+DIGIT_W)'(digit) * (n+DIGIT_W)'(b);

endmodule

// File: rtl/barrett_serial_mult.sv
// Digit-serial n x n unsigned multiplier: one 4-bit digit of A per cycle,
// LSD first, partial products folded into a right-shifting 2n-bit accumulator.
module barrett_serial_mult
  import barrett_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [2*n-1:0] p
);

  localparam int DIGITS = n / DIGIT_W;
  localparam int CW     = cnt_width(DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [n-1:0]           a_r, b_r;
  logic [2*n-1:0]         acc, acc_nxt;
  logic [n+DIGIT_W-1:0]   pp, sum;
  logic                   accept, last;

  // A new operation may begin from IDLE or straight out of DONE (no bubble).
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign last   = (state == S_RUN) && (cnt == CNT_LAST);

  Multiplier_4xN #(.n(n)) u_mul (
    .digit (a_r[DIGIT_W-1:0]),
    .b     (b_r),
    .pp    (pp)
  );

  // High half of acc plus this digit's partial product fits in n+4 bits;
  // the low digit of acc drops into the growing result below it.
  assign sum     = {{DIGIT_W{1'b0}}, acc[2*n-1:n]} + pp;
  assign acc_nxt = {sum, acc[n-1:DIGIT_W]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = start ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, digit shifting, accumulation and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      p   <= '0;
    end else if (accept) begin
      cnt <= '0;
      a_r <= a;
      b_r <= b;
      acc <= '0;
    end else if (state == S_RUN) begin
      cnt <= cnt + CW'(1);
      a_r <= a_r >> DIGIT_W;
      acc <= acc_nxt;
      if (last) p <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_barrett_serial_mult.sv
// Scoreboard bench: drivers push expected product and done cycle, monitors
// pop and compare whenever done is seen. Covers n=8 directed and n=16 random.
module tb_barrett_serial_mult;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        start16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  barrett_serial_mult #(.n(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  barrett_serial_mult #(.n(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .p(p16)
  );

  typedef struct {
    logic [31:0] p;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16, ed;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // n=8 monitor: every done must match the oldest outstanding request.
  initial forever begin
    @(posedge clk); #1;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) check("done8_unexpected", 32'(done8), 32'd0);
      else begin
        e8 = q8.pop_front();
        check("p8", 32'(p8), e8.p);
        check("done8_cycle", 32'(cyc), 32'(e8.cyc));
      end
    end
  end

  // n=16 monitor.
  initial forever begin
    @(posedge clk); #1;
    if (done16 === 1'b1) begin
      if (q16.size() == 0) check("done16_unexpected", 32'(done16), 32'd0);
      else begin
        e16 = q16.pop_front();
        check("p16", p16, e16.p);
        check("done16_cycle", 32'(cyc), 32'(e16.cyc));
      end
    end
  end

  task automatic drain8();
    for (int i = 0; i < 20 && q8.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    check("drain8", 32'(q8.size()), 32'd0);
  endtask

  task automatic drain16();
    for (int i = 0; i < 20 && q16.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    check("drain16", 32'(q16.size()), 32'd0);
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    @(negedge clk); start8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk); #1;
    ed.p = 32'(exp); ed.cyc = cyc + 2; q8.push_back(ed);
    check("busy8_after_start", 32'(busy8), 32'd1);
    @(negedge clk); start8 = 1'b0;
    drain8();
  endtask

  task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    @(negedge clk); start16 = 1'b1; a16 = a; b16 = b;
    @(posedge clk); #1;
    ed.p = exp; ed.cyc = cyc + 4; q16.push_back(ed);
    check("busy16_after_start", 32'(busy16), 32'd1);
    @(negedge clk); start16 = 1'b0;
    drain16();
  endtask

  logic [15:0] hold_exp [3];

  initial begin
    rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_p8",    32'(p8),    32'd0);
    check("rst_busy16", 32'(busy16), 32'd0);
    check("rst_done16", 32'(done16), 32'd0);
    check("rst_p16",    p16,         32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);

    // Full-scale, zero and unit operands.
    run_op8(8'hFF, 8'hFF, 16'hFE01);
    run_op8(8'h00, 8'hA5, 16'h0000);
    run_op8(8'h01, 8'hA5, 16'h00A5);
    run_op8(8'hA5, 8'h00, 16'h0000);

    // start held high: back-to-back products, A changed mid-RUN.
    hold_exp[0] = 16'h03A8; hold_exp[1] = 16'h03A8; hold_exp[2] = 16'h1178;
    @(negedge clk); start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ed.p = 32'(hold_exp[i]); ed.cyc = cyc + 2; q8.push_back(ed);
      if (i == 1) begin @(negedge clk); a8 = 8'h56; end
      repeat (2) @(posedge clk);
    end
    @(negedge clk); start8 = 1'b0;
    drain8();

    // start pulsed while busy with other operands: ignored.
    @(negedge clk); start8 = 1'b1; a8 = 8'h0F; b8 = 8'h0F;
    @(posedge clk); #1;
    ed.p = 32'h00E1; ed.cyc = cyc + 2; q8.push_back(ed);
    @(negedge clk); a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk); start8 = 1'b0;
    drain8();

    // Reset mid-RUN abandons the operation.
    @(negedge clk); start8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
    @(negedge clk); start8 = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("midrun_rst_busy8", 32'(busy8), 32'd0);
    check("midrun_rst_done8", 32'(done8), 32'd0);
    check("midrun_rst_p8",    32'(p8),    32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(posedge clk);

    // Reset together with start: reset wins.
    @(negedge clk); rst = 1'b1; start8 = 1'b1; a8 = 8'h03; b8 = 8'h03;
    @(posedge clk); #1;
    check("rst_start_busy8", 32'(busy8), 32'd0);
    @(negedge clk); rst = 1'b0; start8 = 1'b0;
    repeat (6) @(posedge clk);
    run_op8(8'h03, 8'h03, 16'h0009);

    // n=16 directed.
    run_op16(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run_op16(16'h0000, 16'h1234, 32'h00000000);
    run_op16(16'h0100, 16'h0100, 32'h00010000);

    // n=16 random, start held, new operands loaded during each RUN.
    @(negedge clk); start16 = 1'b1;
    a16 = 16'($urandom); b16 = 16'($urandom);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      ed.p = 32'(a16) * 32'(b16); ed.cyc = cyc + 4; q16.push_back(ed);
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom);
      if (i == 999) start16 = 1'b0;
      repeat (4) @(posedge clk);
    end
    drain16();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
